// File: rtl/pmalu_pkg.sv
// Shared state encodings and opcode constants for the poor-man's ALU board.
package pmalu_pkg;

    typedef enum logic [1:0] {
        S_A   = 2'b00,
        S_B   = 2'b01,
        S_OP  = 2'b10,
        S_RES = 2'b11
    } state_t;

    localparam logic [2:0] OP_ADD  = 3'd0;
    localparam logic [2:0] OP_SUB  = 3'd1;
    localparam logic [2:0] OP_AND  = 3'd2;
    localparam logic [2:0] OP_OR   = 3'd3;
    localparam logic [2:0] OP_XOR  = 3'd4;
    localparam logic [2:0] OP_NOTA = 3'd5;
    localparam logic [2:0] OP_SHL  = 3'd6;
    localparam logic [2:0] OP_SHR  = 3'd7;

endpackage

// File: rtl/key_debouncer.sv
// Pushbutton synchronizer, debouncer and press-edge pulse generator.
// Counter-based debouncing is enabled by PMALU_DEBOUNCE_EN; otherwise the synchronized level is used directly.
module key_debouncer #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst,
    input  logic key_n,
    output logic step
);

    if (DEBOUNCE_CYCLES < 2) begin : g_param_check
        $error("DEBOUNCE_CYCLES must be at least 2");
    end

    logic key_p0, key_p1;
    logic deb, deb_q;

    // Synchronizer stage: both flops reset to the released level
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key_p0 <= 1'b1;
            key_p1 <= 1'b1;
        end else begin
            key_p0 <= key_n;
            key_p1 <= key_p0;
        end
    end

`ifdef PMALU_DEBOUNCE_EN
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    logic [CNT_W-1:0] cnt;

    // Debounce stage: level is accepted after DEBOUNCE_CYCLES consecutive differing samples
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            deb <= 1'b1;
            cnt <= '0;
        end else if (key_p1 == deb) begin
            cnt <= '0;
        end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
            deb <= key_p1;
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end
`else
    assign deb = key_p1;
`endif

    // Edge stage: one pulse per released-to-pressed transition
    always_ff @(posedge clk or posedge rst) begin
        if (rst) deb_q <= 1'b1;
        else     deb_q <= deb;
    end

    assign step = deb_q & ~deb;

endmodule

// File: rtl/alu_entry_sequencer.sv
// Operand/opcode entry sequencer and 4-bit ALU for the poor-man's ALU board.
// Key debouncing is controlled by the PMALU_DEBOUNCE_EN macro inside key_debouncer.
module alu_entry_sequencer
    import pmalu_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] sw,
    input  logic       key_n,
    output logic [3:0] bcd,
    output logic [1:0] phase,
    output logic       carry,
    output logic       zero,
    output logic       result_valid
);

    state_t     state, state_next;
    logic       step;
    logic [3:0] a_reg, b_reg, res_reg;
    logic [2:0] op;
    logic [4:0] alu_out;

    // Returns {flag, result}; 5-bit subtraction leaves the borrow in bit 4
    function automatic logic [4:0] alu(input logic [3:0] a, input logic [3:0] b,
                                       input logic [2:0] opc);
        logic [4:0] r;
        case (opc)
            OP_ADD:  r = {1'b0, a} + {1'b0, b};
            OP_SUB:  r = {1'b0, a} - {1'b0, b};
            OP_AND:  r = {1'b0, a & b};
            OP_OR:   r = {1'b0, a | b};
            OP_XOR:  r = {1'b0, a ^ b};
            OP_NOTA: r = {1'b0, ~a};
            OP_SHL:  r = {a[3], a[2:0], 1'b0};
            default: r = {a[0], 1'b0, a[3:1]};
        endcase
        return r;
    endfunction

    key_debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb (
        .clk  (clk),
        .rst  (rst),
        .key_n(key_n),
        .step (step)
    );

    assign op      = sw[2:0];
    assign alu_out = alu(a_reg, b_reg, op);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_A;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (step) begin
            case (state)
                S_A:     state_next = S_B;
                S_B:     state_next = S_OP;
                S_OP:    state_next = S_RES;
                default: state_next = S_A;
            endcase
        end
    end

    // Operand capture, result/flag registers and the registered display value
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_reg   <= '0;
            b_reg   <= '0;
            res_reg <= '0;
            carry   <= 1'b0;
            zero    <= 1'b0;
            bcd     <= '0;
        end else begin
            if (step) begin
                case (state)
                    S_A: a_reg <= sw;
                    S_B: b_reg <= sw;
                    S_OP: begin
                        res_reg <= alu_out[3:0];
                        carry   <= alu_out[4];
                        zero    <= (alu_out[3:0] == 4'd0);
                    end
                    default: begin
                        a_reg   <= '0;
                        b_reg   <= '0;
                        res_reg <= '0;
                        carry   <= 1'b0;
                        zero    <= 1'b0;
                    end
                endcase
            end
            bcd <= (state == S_RES) ? res_reg : sw;
        end
    end

    assign phase        = state;
    assign result_valid = (state == S_RES);

endmodule
